bsearch_ctrl: RTL and testbench
===============================

# bsearch_ctrl

Sequential binary-search controller that locates a key in a sorted table held in an external synchronous-read RAM. It is the driving side of the team's COMP magnitude comparator: it sources both comparator operands (cmp_a, cmp_b) and consumes its gt/lt/eq flags to steer the search. The parent instantiates COMP alongside it, wiring cmp_a/cmp_b to COMP a/b and COMP gt/lt/eq back to this block.

## Interface

Parameters:
- DATAWIDTH, 8, width of table entries, key and comparator operands
- ADDRWIDTH, 4, table address width; table holds 2^ADDRWIDTH entries sorted ascending, unsigned

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  reset; one clock, reset is synchronous and active-low
- start  input  1  begin search; sampled only in IDLE
- key  input  DATAWIDTH  value to find; latched on accepted start
- mem_en  output  1  RAM read enable
- mem_addr  output  ADDRWIDTH  RAM read address
- mem_data  input  DATAWIDTH  RAM read data, valid one cycle after mem_en/mem_addr
- cmp_a  output  DATAWIDTH  comparator operand a (latched key)
- cmp_b  output  DATAWIDTH  comparator operand b (latched table entry)
- gt, lt, eq  input  1 each  comparator flags for cmp_a vs cmp_b, combinational
- busy  output  1  high from accepted start until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- found  output  1  key present; held until next accepted start
- index  output  ADDRWIDTH+1  match index if found, else insertion point (0..2^ADDRWIDTH); held until next accepted start

## Operation

- Registers: key_q, data_q (DATAWIDTH); lo, hi (ADDRWIDTH+1, half-open range [lo,hi)); mid = (lo+hi)>>1, computed in ADDRWIDTH+1 bits.
- States: IDLE, ADDR, WAIT, CMP, DONE.
- IDLE: start=1 -> key_q<=key, lo<=0, hi<=2^ADDRWIDTH, found<=0, index<=0, -> ADDR. start=0 -> stay.
- ADDR: mem_en=1, mem_addr=mid[ADDRWIDTH-1:0]; -> WAIT.
- WAIT: data_q<=mem_data; -> CMP.
- CMP: flags evaluated on cmp_a=key_q, cmp_b=data_q.
  - eq: found<=1, index<=mid, -> DONE.
  - gt (key > entry): lo<=mid+1.
  - lt (key < entry): hi<=mid.
  - after gt/lt: if updated lo==hi -> found<=0, index<=updated lo, -> DONE; else -> ADDR.
  - no flag or multiple flags asserted (illegal): treat as not found, index<=lo, -> DONE.
- DONE: done=1, busy=1; -> IDLE.
- Half-open range guarantees no underflow at index 0; hi never exceeds 2^ADDRWIDTH.
- start in any state other than IDLE is ignored; key changes after acceptance have no effect.
- Rst=0 on any edge, including mid-search: state<=IDLE, search aborted, no done pulse.

## Timing

- Reset values: mem_en=0, mem_addr=0, cmp_a=0, cmp_b=0, busy=0, done=0, found=0, index=0; key_q, data_q, lo, hi cleared.
- mem_addr = mid in every state; mem_en high only in ADDR.
- Each probe = 3 cycles (ADDR, WAIT, CMP). Start accepted at edge ending cycle 0; probe p (1-based) CMP in cycle 3p; done in cycle 3p+1.
- Max probes ADDRWIDTH+1; worst-case done at cycle 3(ADDRWIDTH+1)+1 (16 for default).
- busy rises the cycle after accepted start; falls after DONE. New start is accepted in the cycle after DONE at the earliest.
- cmp_a, cmp_b registered; flags must settle within one cycle.

## Structure

- Package bsearch_pkg: state encoding localparams (IDLE, ADDR, WAIT, CMP, DONE, 3-bit), default DATAWIDTH/ADDRWIDTH.
- Single flat FSM+datapath module; no sub-module. Comparator remains external (COMP in parent); bench instantiates COMP plus a behavioural 1-cycle RAM.

## Test plan

Table (defaults): entry[i] = 4i+2, i.e. 2,6,...,62.
- key=34 -> one probe at addr 8, eq; done at cycle 4, found=1, index=8.
- key=30 -> probes 8(lt),4(gt),6(gt),7(eq); done at cycle 13, found=1, index=7.
- key=0 -> probes 8,4,2,1,0 all lt; done at cycle 16, found=0, index=0; mem_addr never wraps.
- key=63 -> probes 8,12,14,15 all gt; done at cycle 13, found=0, index=16.
- start pulsed with key=2 during probe 2 of a key=30 search -> ignored, key=30 result unchanged; Rst=0 during WAIT of a new search -> next cycle IDLE, busy=0, no done, found/index=0.
- Illegal flags (bench forces gt=lt=0, eq=0 in first CMP) -> done at cycle 4, found=0, index=0.

Source files
------------

// File: rtl/bsearch_ctrl_pkg.sv
// bsearch_ctrl shared definitions.
// State encoding and default table geometry.
package bsearch_pkg;

  localparam int DATAWIDTH_D = 8;
  localparam int ADDRWIDTH_D = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/bsearch_ctrl_if.sv
// RAM read port and comparator operand/flag bundle.
// master = search controller, slave = RAM + COMP side.
interface bsearch_ctrl_if
  import bsearch_pkg::*;
#(
  parameter int DW = DATAWIDTH_D,
  parameter int AW = ADDRWIDTH_D
);

  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] cmp_a;
  logic [DW-1:0] cmp_b;
  logic          gt;
  logic          lt;
  logic          eq;

  modport master (
    output mem_en, mem_addr,
    output cmp_a, cmp_b,
    input  mem_data,
    input  gt, lt, eq
  );

  modport slave (
    input  mem_en, mem_addr,
    input  cmp_a, cmp_b,
    output mem_data,
    output gt, lt, eq
  );

endinterface

// File: rtl/bsearch_ctrl.sv
// Binary search over a sorted synchronous-read RAM,
// steered by an external magnitude comparator.
module bsearch_ctrl
  import bsearch_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_D,
  parameter int ADDRWIDTH = ADDRWIDTH_D
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] key,
  bsearch_ctrl_if.master       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [ADDRWIDTH:0]   index
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] TOP =
    PW'(1) << ADDRWIDTH;

  state_t               state;
  logic [DATAWIDTH-1:0] key_q;
  logic [DATAWIDTH-1:0] data_q;
  logic [PW-1:0]        lo;
  logic [PW-1:0]        hi;
  logic [PW-1:0]        mid;
  logic [PW-1:0]        mid_p1;

  // Extra carry bit keeps lo==hi==TOP from folding to 0.
  function automatic logic [PW-1:0] mid_of(
    input logic [PW-1:0] l,
    input logic [PW-1:0] h
  );
    logic [PW:0] s;
    s = {1'b0, l} + {1'b0, h};
    return s[PW:1];
  endfunction

  assign mid    = mid_of(lo, hi);
  assign mid_p1 = mid + PW'(1);

  assign bus.cmp_a = key_q;
  assign bus.cmp_b = data_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state        <= IDLE;
      key_q        <= '0;
      data_q       <= '0;
      lo           <= '0;
      hi           <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      index        <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q        <= key;
            lo           <= '0;
            hi           <= TOP;
            found        <= 1'b0;
            index        <= '0;
            busy         <= 1'b1;
            bus.mem_en   <= 1'b1;
            bus.mem_addr <=
              ADDRWIDTH'(mid_of('0, TOP));
            state        <= ADDR;
          end
        end
        ADDR: state <= WAIT;
        WAIT: begin
          data_q <= bus.mem_data;
          state  <= CMP;
        end
        CMP: begin
          case ({bus.gt, bus.lt, bus.eq})
            3'b001: begin
              found <= 1'b1;
              index <= mid;
              done  <= 1'b1;
              state <= DONE;
            end
            3'b100: begin
              lo           <= mid_p1;
              bus.mem_addr <=
                ADDRWIDTH'(mid_of(mid_p1, hi));
              if (mid_p1 == hi) begin
                index <= mid_p1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                bus.mem_en <= 1'b1;
                state      <= ADDR;
              end
            end
            3'b010: begin
              hi           <= mid;
              bus.mem_addr <=
                ADDRWIDTH'(mid_of(lo, mid));
              if (lo == mid) begin
                index <= lo;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                bus.mem_en <= 1'b1;
                state      <= ADDR;
              end
            end
            default: begin
              index <= lo;
              done  <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Directed bench for bsearch_ctrl with a 1-cycle RAM,
// inline comparator and an expected-result scoreboard.
module tb_bsearch_ctrl;
  import bsearch_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          kill  = 1'b0;
  logic [DW-1:0] key   = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW:0]   index;

  bsearch_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  bsearch_ctrl #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW)
  ) dut (
    .Clk  (clk),
    .Rst  (rst_n),
    .start(start),
    .key  (key),
    .bus  (bus),
    .busy (busy),
    .done (done),
    .found(found),
    .index(index)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**AW];

  always @(posedge clk)
    if (bus.mem_en) bus.mem_data <= ram[bus.mem_addr];

  assign bus.gt = !kill && (bus.cmp_a > bus.cmp_b);
  assign bus.lt = !kill && (bus.cmp_a < bus.cmp_b);
  assign bus.eq = !kill && (bus.cmp_a == bus.cmp_b);

  typedef struct {
    int          cyc;
    logic        f;
    logic [AW:0] idx;
    logic [DW-1:0] k;
  } res_t;

  res_t exp_q[$];
  int   addr_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic search(input logic [DW-1:0] k,
                        input logic ef,
                        input int eidx,
                        input int ecyc,
                        input int inj_at);
    res_t r;
    bit   got;
    r.cyc = ecyc;
    r.f   = ef;
    r.idx = (AW+1)'(eidx);
    r.k   = k;
    exp_q.push_back(r);
    got = 0;
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = DW'($urandom);
    for (int n = 1; n <= 40 && !got; n++) begin
      if (n == inj_at) begin
        start = 1'b1;
        key   = 8'd2;
      end else if (n == inj_at + 1) begin
        start = 1'b0;
      end
      if (bus.mem_en) begin
        if (addr_q.size() > 0) begin
          chk("probe_addr", 32'(bus.mem_addr),
              32'(addr_q.pop_front()));
        end else begin
          n_cmp++;
          n_bad++;
          $error("FAIL extra_probe: observed %0d expected none",
                 bus.mem_addr);
        end
      end
      if (done) begin
        r = exp_q.pop_front();
        got = 1;
        chk("done_cycle", 32'(n), 32'(r.cyc));
        chk("found", 32'(found), 32'(r.f));
        chk("index", 32'(index), 32'(r.idx));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("cmp_a_key", 32'(bus.cmp_a), 32'(r.k));
        chk("probes_left", 32'(addr_q.size()), 32'd0);
      end else begin
        chk("busy_run", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: observed no done expected cycle %0d",
             ecyc);
      void'(exp_q.pop_front());
      addr_q.delete();
    end
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 2**AW; i++)
      ram[i] = DW'(4*i + 2);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
    chk("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    addr_q = '{8};
    search(8'd34, 1'b1, 8, 4, 0);

    addr_q = '{8, 4, 6, 7};
    search(8'd30, 1'b1, 7, 13, 0);

    addr_q = '{8, 4, 2, 1, 0};
    search(8'd0, 1'b0, 0, 16, 0);

    addr_q = '{8, 12, 14, 15};
    search(8'd63, 1'b0, 16, 13, 0);

    addr_q = '{8, 4, 6, 7};
    search(8'd30, 1'b1, 7, 13, 4);

    @(negedge clk);
    start = 1'b1;
    key   = 8'd62;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_index", 32'(index), 32'd0);
    chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("abort_quiet", 32'(pulses), 32'd0);

    addr_q = '{8, 12, 14, 15};
    search(8'd62, 1'b1, 15, 13, 0);

    kill = 1'b1;
    addr_q = '{8};
    search(8'd30, 1'b0, 0, 4, 0);
    kill = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
